scan_cfg_loader: RTL

- Drives the configuration scan chain (conn_scan_en / conn_scan_in / conn_scan_out) of the fabric edge and tile columns from a host-side word stream.
- Serializes CHAIN_LEN configuration bits, LSB of each word first, into the chain.
- Has an optional verify pass: the same stream is shifted in again, and each bit emerging at conn_scan_out is compared with the bit being shifted in.
- Sits between the chip-level config port and the first conn_scan_in of the fabric.

---
 rtl/cfg_pkg.sv | 18 +
 rtl/scan_word_serializer.sv | 42 ++++
 rtl/scan_cfg_loader.sv | 107 ++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// Shared state encoding and sizing helpers
// for the configuration scan-chain loader.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_e;

  localparam int CHAIN_LEN_DEF = 1024;

  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/scan_word_serializer.sv
// Word-wide shift register feeding the chain
// one bit per shift, LSB first.
module scan_word_serializer
  import cfg_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int WB_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  input  logic [WB_W-1:0]   nbits,
  output logic              sout,
  output logic              last
);

  logic [WORD_W-1:0] sreg;
  logic [WB_W-1:0]   word_bits;

  assign last = (word_bits == WB_W'(1));

  // sout holds its value after the final bit so the
  // chain input stays stable while shifting is paused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      word_bits <= '0;
      sout      <= 1'b0;
    end else if (load) begin
      sreg      <= data;
      word_bits <= nbits;
      sout      <= data[0];
    end else if (shift) begin
      sreg      <= sreg >> 1;
      word_bits <= word_bits - WB_W'(1);
      if (!last) sout <= sreg[1];
    end
  end

endmodule

// File: rtl/scan_cfg_loader.sv
// Host word stream to configuration scan chain,
// with an optional read-back verify pass.
module scan_cfg_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = cnt_w(CHAIN_LEN)
) (
  input  logic              scan_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              conn_scan_en,
  output logic              conn_scan_in,
  input  logic              conn_scan_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam int WB_W = $clog2(WORD_W + 1);

  state_e           state, state_d;
  logic             mode;
  logic [CNT_W-1:0] bits_left;
  logic [WB_W-1:0]  load_bits;
  logic             accept;
  logic             shift;
  logic             last;

  assign cfg_ready = (state == FETCH);
  assign accept    = cfg_ready && cfg_valid;
  assign shift     = (state == SHIFT);

  always_comb begin
    load_bits = WB_W'(WORD_W);
    if (int'(bits_left) < WORD_W)
      load_bits = WB_W'(bits_left);
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (start) state_d = FETCH;
      FETCH: if (cfg_valid) state_d = SHIFT;
      SHIFT: if (last)
               state_d = (bits_left == CNT_W'(1)) ? DONE : FETCH;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode         <= 1'b0;
      bits_left    <= '0;
      conn_scan_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      state        <= state_d;
      conn_scan_en <= (state_d == SHIFT);
      busy         <= (state_d != IDLE);
      done         <= (state_d == DONE);
      if (state == IDLE && start) begin
        mode      <= verify;
        bits_left <= CNT_W'(CHAIN_LEN);
        if (verify) begin
          err          <= 1'b0;
          mismatch_cnt <= '0;
        end
      end
      if (shift) begin
        bits_left <= bits_left - CNT_W'(1);
        // returning bit should equal the bit sent this cycle
        if (mode && (conn_scan_out != conn_scan_in)) begin
          err <= 1'b1;
          if (mismatch_cnt != '1)
            mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        end
      end
    end
  end

  scan_word_serializer #(
    .WORD_W (WORD_W),
    .WB_W   (WB_W)
  ) u_ser (
    .clk   (scan_clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift (shift),
    .data  (cfg_data),
    .nbits (load_bits),
    .sout  (conn_scan_in),
    .last  (last)
  );

endmodule
